// File: rtl/apb_timer.sv
// ---------------------------------------------------------------------------
// apb_timer
//
// 32-bit down-counting timer on the APB side of the AHB-lite-to-APB bridge
// (slave slot 2). It has a programmable prescaler, one-shot or periodic
// mode, a sticky interrupt flag and a level interrupt output.
//
// Register map (byte offset, only paddr[11:2] decoded):
//   0x00 CTRL     RW  [0] EN, [1] MODE (1 = periodic), [2] IRQ_EN
//   0x04 PRESCALE RW  [PRESCALE_W-1:0]
//   0x08 LOAD     RW  reload value
//   0x0C VALUE    RO  current count
//   0x10 STATUS   W1C [0] IF (sticky expiry flag)
//   0x14 COMPARE  RW  PWM compare value (only with TIMER_PWM_EN)
//
// Optional feature macro: TIMER_PWM_EN
//   defined   : COMPARE register exists, pwm_o <= EN & (VALUE < COMPARE)
//   undefined : 0x14 reads 0 and ignores writes, pwm_o tied low
//
// Ports:
//   clk      system clock, rising edge
//   rst      asynchronous active-high reset
//   paddr    APB address
//   psel     slave select
//   penable  APB access phase
//   pwrite   1 = write, 0 = read
//   pwdata   write data
//   prdata   read data (combinational, 0 unless psel & ~pwrite)
//   irq_o    level interrupt = STATUS.IF & CTRL.IRQ_EN
//   pwm_o    PWM output (0 unless TIMER_PWM_EN)
// ---------------------------------------------------------------------------
module apb_timer #(
    parameter int          PRESCALE_W = 16,
    parameter logic [31:0] RESET_LOAD = 32'h0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] paddr,
    input  logic        psel,
    input  logic        penable,
    input  logic        pwrite,
    input  logic [31:0] pwdata,
    output logic [31:0] prdata,
    output logic        irq_o,
    output logic        pwm_o
);

    localparam logic [9:0] OFF_CTRL     = 10'h000;
    localparam logic [9:0] OFF_PRESCALE = 10'h001;
    localparam logic [9:0] OFF_LOAD     = 10'h002;
    localparam logic [9:0] OFF_VALUE    = 10'h003;
    localparam logic [9:0] OFF_STATUS   = 10'h004;
    localparam logic [9:0] OFF_COMPARE  = 10'h005;

    // Architectural state
    logic                  en_reg,       en_next;
    logic                  mode_reg,     mode_next;
    logic                  irq_en_reg,   irq_en_next;
    logic [PRESCALE_W-1:0] prescale_reg, prescale_next;
    logic [31:0]           load_reg,     load_next;
    logic [31:0]           value_reg,    value_next;
    logic                  if_reg,       if_next;
    logic [PRESCALE_W-1:0] pcnt_reg,     pcnt_next;

    // Decode
    logic [9:0] reg_idx;
    logic       wr_en;
    logic       wr_ctrl;
    logic       wr_prescale;
    logic       wr_load;
    logic       wr_status;
    logic       tick;
    logic       expire;
    logic       start_wr;
    logic       stop_wr;

    // Address bits outside the decoded window are intentionally ignored.
    logic unused_addr_bits;
    assign unused_addr_bits = ^{paddr[31:12], paddr[1:0]};

    assign reg_idx     = paddr[11:2];
    assign wr_en       = psel & penable & pwrite;
    assign wr_ctrl     = wr_en && (reg_idx == OFF_CTRL);
    assign wr_prescale = wr_en && (reg_idx == OFF_PRESCALE);
    assign wr_load     = wr_en && (reg_idx == OFF_LOAD);
    assign wr_status   = wr_en && (reg_idx == OFF_STATUS);

    // Tick and expiry are judged on the registered state, so a CTRL write in
    // the same cycle cannot suppress the IF set of a tick already due.
    assign tick     = en_reg && (pcnt_reg == prescale_reg);
    assign expire   = tick && (value_reg == 32'd0);
    assign start_wr = wr_ctrl && pwdata[0] && !en_reg;
    assign stop_wr  = wr_ctrl && !pwdata[0];

    always_comb begin
        en_next       = en_reg;
        mode_next     = mode_reg;
        irq_en_next   = irq_en_reg;
        prescale_next = prescale_reg;
        load_next     = load_reg;
        value_next    = value_reg;
        if_next       = if_reg;
        pcnt_next     = pcnt_reg;

        if (wr_ctrl) begin
            en_next     = pwdata[0];
            mode_next   = pwdata[1];
            irq_en_next = pwdata[2];
        end
        if (wr_prescale) begin
            prescale_next = pwdata[PRESCALE_W-1:0];
        end
        if (wr_load) begin
            load_next = pwdata;
        end

        if (start_wr) begin
            value_next = load_next;
            pcnt_next  = '0;
        end else if (en_reg && !stop_wr) begin
            // A stopping write freezes VALUE and the prescaler in its own cycle.
            pcnt_next = tick ? '0 : pcnt_reg + PRESCALE_W'(1);
            if (tick) begin
                if (value_reg != 32'd0) begin
                    value_next = value_reg - 32'd1;
                end else if (mode_reg) begin
                    value_next = load_reg;
                end else if (!wr_ctrl) begin
                    // One-shot end; an explicit CTRL write this cycle wins.
                    en_next = 1'b0;
                end
            end
        end

        // Set beats a same-cycle write-1-to-clear.
        if (wr_status && pwdata[0]) begin
            if_next = 1'b0;
        end
        if (expire) begin
            if_next = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            en_reg       <= 1'b0;
            mode_reg     <= 1'b0;
            irq_en_reg   <= 1'b0;
            prescale_reg <= '0;
            load_reg     <= RESET_LOAD;
            value_reg    <= 32'd0;
            if_reg       <= 1'b0;
            pcnt_reg     <= '0;
        end else begin
            en_reg       <= en_next;
            mode_reg     <= mode_next;
            irq_en_reg   <= irq_en_next;
            prescale_reg <= prescale_next;
            load_reg     <= load_next;
            value_reg    <= value_next;
            if_reg       <= if_next;
            pcnt_reg     <= pcnt_next;
        end
    end

    assign irq_o = if_reg & irq_en_reg;

`ifdef TIMER_PWM_EN
    logic [31:0] compare_reg;
    logic        pwm_reg;
    logic        wr_compare;

    assign wr_compare = wr_en && (reg_idx == OFF_COMPARE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            compare_reg <= 32'd0;
            pwm_reg     <= 1'b0;
        end else begin
            if (wr_compare) begin
                compare_reg <= pwdata;
            end
            pwm_reg <= en_reg & (value_reg < compare_reg);
        end
    end

    assign pwm_o = pwm_reg;
`else
    assign pwm_o = 1'b0;
`endif

    // Read mux: combinational so data is valid in the access phase.
    always_comb begin
        prdata = 32'd0;
        if (psel && !pwrite) begin
            case (reg_idx)
                OFF_CTRL:     prdata = {29'd0, irq_en_reg, mode_reg, en_reg};
                OFF_PRESCALE: prdata = 32'(prescale_reg);
                OFF_LOAD:     prdata = load_reg;
                OFF_VALUE:    prdata = value_reg;
                OFF_STATUS:   prdata = {31'd0, if_reg};
`ifdef TIMER_PWM_EN
                OFF_COMPARE:  prdata = compare_reg;
`endif
                default:      prdata = 32'd0;
            endcase
        end
    end

endmodule

// File: doc/apb_timer.md
Name: apb_timer

Overview:
- 32-bit down-counting timer peripheral on the APB side of the AHB-lite-to-APB bridge.
- Occupies slave slot 2 (0x4001_1000–0x4001_1FFF). Consumes paddr/psel_s2/penable/pwrite/pwdata; returns prdata_s2.
- Provides a programmable prescaler, one-shot or periodic mode, a sticky interrupt flag and a level interrupt output.

Parameters:
PRESCALE_W, 16, width of the prescaler register and prescaler counter (1..32)
RESET_LOAD, 32'h0, reset value of the LOAD register

Ports:
clk  input  1  system clock; all logic on rising edge
rst  input  1  asynchronous, active-high reset
paddr  input  32  APB address; only paddr[11:2] decoded
psel  input  1  slave select (bridge psel_s2)
penable  input  1  APB access phase
pwrite  input  1  1 = write, 0 = read
pwdata  input  32  write data
prdata  output  32  read data, combinational
irq_o  output  1  interrupt, level, = STATUS.IF & CTRL.IRQ_EN
pwm_o  output  1  PWM output (optional feature, else 0)

Behaviour:
- APB protocol
  - No pready: every access completes in the access phase (psel & penable), one cycle after setup.
  - Write commits on the clk edge where psel & penable & pwrite.
  - Reads have no side effects.
  - prdata = selected register whenever psel=1 and pwrite=0; otherwise 0. It must be valid during the access phase; the bridge samples it then.
  - Unmapped offsets read 0; writes to them are ignored.
- Register map (byte offset):
  - 0x00 CTRL, RW: [0] EN, [1] MODE (0 one-shot, 1 periodic), [2] IRQ_EN; other bits read 0.
  - 0x04 PRESCALE, RW: [PRESCALE_W-1:0].
  - 0x08 LOAD, RW: 32 bits.
  - 0x0C VALUE, RO: current count; writes ignored.
  - 0x10 STATUS: [0] IF, sticky; write 1 clears, write 0 has no effect.
- Reset values:
  - CTRL=0, PRESCALE=0, LOAD=RESET_LOAD, VALUE=0, IF=0, prescaler counter=0.
  - Outputs: prdata=0, irq_o=0, pwm_o=0.
  - Reset mid-count aborts the count immediately; no expiry event is generated.
- Start:
  - A write setting EN from 0 to 1 loads VALUE <= LOAD (using the LOAD value after the same-cycle write) and clears the prescaler counter.
  - Writing EN=1 while EN is already 1 does not restart the count.
- Prescaler (when EN=1):
  - The prescaler counter increments each cycle.
  - When it equals PRESCALE, the cycle is a tick and the counter returns to 0.
  - PRESCALE=0 gives a tick every cycle.
- Count on each tick:
  - VALUE≠0: VALUE <= VALUE-1.
  - VALUE==0: expiry. IF <= 1. Periodic: VALUE <= LOAD. One-shot: EN <= 0 and VALUE holds 0.
  - Expiry period = (LOAD+1)*(PRESCALE+1) cycles from start.
- Stop: writing EN=0 freezes VALUE and the prescaler counter. A later 0→1 write reloads as on start.
- Boundary cases:
  - LOAD=0 in periodic mode: expiry on every tick.
  - LOAD written while running: takes effect only at the next reload or start.
  - PRESCALE written while running: the new compare value applies from the next cycle; a prescaler counter already above the new PRESCALE runs until it wraps through 2^PRESCALE_W−1 (documented, not an error).
  - Expiry in the same cycle as a W1C of IF: the set wins, IF=1.
  - Same-cycle write of EN=0 and an expiry tick: the write wins. No decrement or reload; IF is still set by the tick.
- irq_o is combinational from the registered IF and IRQ_EN; no extra latency.

Optional Feature:
- Macro: TIMER_PWM_EN.
- Defined:
  - Adds register 0x14 COMPARE, RW, 32 bits, reset 0.
  - pwm_o is registered: pwm_o <= EN & (VALUE < COMPARE).
  - COMPARE=0 gives constant low; COMPARE > LOAD gives high for the whole period while EN=1.
- Undefined:
  - No COMPARE flops; offset 0x14 reads 0 and ignores writes.
  - pwm_o is tied to 0.

Test Plan:
- Reset, then read all offsets 0x00–0x14 and 0x18 -> all 0 except LOAD=RESET_LOAD; irq_o=0, pwm_o=0.
- LOAD=3, PRESCALE=0, CTRL=0x7 (EN, periodic, IRQ_EN) -> VALUE reads 3,2,1,0; IF and irq_o rise every 4 cycles; VALUE reloads to 3.
- LOAD=2, PRESCALE=4, CTRL=0x1 (one-shot) -> expiry 15 cycles after the enabling write; EN reads 0; VALUE holds 0; irq_o stays 0 (IRQ_EN=0) while IF=1.
- Write STATUS=1 in the exact cycle of a periodic expiry -> IF remains 1; a later write of STATUS=1 clears IF and irq_o; write STATUS=0 -> no change.
- Running, LOAD=10: write LOAD=5 mid-count -> the current period completes from 10; the next period counts from 5. Assert rst mid-count -> all registers return to reset values asynchronously.
- TIMER_PWM_EN defined: LOAD=9, PRESCALE=0, COMPARE=3, periodic -> pwm_o high 3 of every 10 cycles. Undefined: 0x14 write 0x55 reads 0, pwm_o=0.
